ahbl_sram_adapter: RTL and testbench

// AHB-Lite subordinate that drives one sram_wrapper instance (its initiator side).

---
 rtl/ahbl_sram_adapter_if.sv | 28 ++
 rtl/ahbl_sram_adapter.sv | 152 +++++++++++++++
 tb/tb_ahbl_sram_adapter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_sram_adapter_if.sv
// AHB-Lite subordinate bus bundle between an initiator and ahbl_sram_adapter.
// Address phase, data phase and response signals share one interface.
interface ahbl_sram_adapter_if #(
    parameter int W_ADDR = 32
);
    logic              hready;
    logic              hready_resp;
    logic              hresp;
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic              hsel;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;

    modport master (
        output hready, haddr, hwrite, htrans,
        output hsize, hsel, hwdata,
        input  hready_resp, hresp, hrdata
    );

    modport slave (
        input  hready, haddr, hwrite, htrans,
        input  hsize, hsel, hwdata,
        output hready_resp, hresp, hrdata
    );
endinterface

// File: rtl/ahbl_sram_adapter.sv
// Zero-wait-state AHB-Lite to single-port SRAM adapter.
// Writes that collide with a read park in a one-entry buffer.
module ahbl_sram_adapter #(
    parameter  int W_ADDR  = 32,
    parameter  int DEPTH   = 2048,
    localparam int W_SADDR = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    ahbl_sram_adapter_if.slave ahbls,
    output logic               sram_cs_n,
    output logic               sram_we_n,
    output logic [3:0]         sram_be_n,
    output logic [W_SADDR-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    logic               aph_valid;
    logic               aph_read;
    logic [3:0]         aph_mask;
    logic [W_SADDR-1:0] aph_addr;

    logic               dph_read;
    logic               dph_write;
    logic [W_SADDR-1:0] dph_addr;
    logic [3:0]         dph_mask;

    logic               wbuf_valid;
    logic [31:0]        wbuf_data;
    logic [W_SADDR-1:0] wbuf_addr;
    logic [3:0]         wbuf_mask;

    logic               active;
    logic               port_read;
    logic               drain;
    logic               direct;
    logic               store;
    logic               fwd;

    logic unused_ok;
    assign unused_ok = &{1'b0, ahbls.htrans[0], ahbls.haddr};

    assign aph_valid = ahbls.hsel & ahbls.htrans[1]
                     & ahbls.hready;
    assign aph_read  = aph_valid & ~ahbls.hwrite;
    assign aph_addr  = ahbls.haddr[W_SADDR+1:2];

    always_comb begin
        aph_mask = 4'hf;
        unique case (1'b1)
            ahbls.hsize == 3'd0:
                aph_mask = 4'b0001 << ahbls.haddr[1:0];
            ahbls.hsize == 3'd1:
                aph_mask = ahbls.haddr[1] ? 4'b1100
                                          : 4'b0011;
            default:
                aph_mask = 4'hf;
        endcase
    end

    // Port stays idle during the first cycle out of reset.
    assign port_read = aph_read & active;
    assign drain     = wbuf_valid & ~port_read;
    assign direct    = dph_write & ~port_read & ~wbuf_valid;
    assign store     = dph_write & port_read;

    always_comb begin
        sram_cs_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be_n  = 4'hf;
        sram_addr  = '0;
        sram_wdata = '0;
        unique case (1'b1)
            port_read: begin
                sram_cs_n = 1'b0;
                sram_addr = aph_addr;
            end
            drain: begin
                sram_cs_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_be_n  = ~wbuf_mask;
                sram_addr  = wbuf_addr;
                sram_wdata = wbuf_data;
            end
            direct: begin
                sram_cs_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_be_n  = ~dph_mask;
                sram_addr  = dph_addr;
                sram_wdata = ahbls.hwdata;
            end
            default: begin
                sram_cs_n = 1'b1;
            end
        endcase
    end

    assign fwd = wbuf_valid & (wbuf_addr == dph_addr);

    always_comb begin
        ahbls.hrdata = '0;
        if (dph_read) begin
            for (int i = 0; i < 4; i++) begin
                ahbls.hrdata[8*i +: 8] =
                    (fwd & wbuf_mask[i])
                        ? wbuf_data[8*i +: 8]
                        : sram_rdata[8*i +: 8];
            end
        end
    end

    assign ahbls.hready_resp = 1'b1;
    assign ahbls.hresp       = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= 1'b0;
            dph_read   <= 1'b0;
            dph_write  <= 1'b0;
            dph_addr   <= '0;
            dph_mask   <= '0;
            wbuf_valid <= 1'b0;
            wbuf_data  <= '0;
            wbuf_addr  <= '0;
            wbuf_mask  <= '0;
        end else begin
            active <= 1'b1;
            if (ahbls.hready) begin
                dph_read  <= aph_valid & ~ahbls.hwrite;
                dph_write <= aph_valid & ahbls.hwrite;
                dph_addr  <= aph_valid ? aph_addr : '0;
                dph_mask  <= aph_valid ? aph_mask : '0;
            end
            if (store) begin
                wbuf_valid <= 1'b1;
                wbuf_data  <= ahbls.hwdata;
                wbuf_addr  <= dph_addr;
                wbuf_mask  <= dph_mask;
            end else if (drain) begin
                wbuf_valid <= 1'b0;
            end
        end
    end

    // The write's own address phase always frees the port for a drain.
    a_no_wr_with_buf: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(dph_write && wbuf_valid)
    );

endmodule

// File: tb/tb_ahbl_sram_adapter.sv
// Directed bench for ahbl_sram_adapter with a behavioural SRAM.
// Each task drives one scenario and checks its own outputs.
module tb_ahbl_sram_adapter;

    localparam int DEPTH = 2048;
    localparam int W_SADDR = $clog2(DEPTH);

    logic               clk;
    logic               rst_n;
    logic               sram_cs_n;
    logic               sram_we_n;
    logic [3:0]         sram_be_n;
    logic [W_SADDR-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;

    int n_run;
    int n_fail;

    ahbl_sram_adapter_if #(.W_ADDR(32)) bus ();

    ahbl_sram_adapter #(
        .W_ADDR(32),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ahbls     (bus),
        .sram_cs_n (sram_cs_n),
        .sram_we_n (sram_we_n),
        .sram_be_n (sram_be_n),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!sram_cs_n) begin
            if (!sram_we_n) begin
                for (int i = 0; i < 4; i++) begin
                    if (!sram_be_n[i])
                        mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic aph(input logic wr, input logic [31:0] a,
                       input logic [2:0] sz);
        bus.hsel   = 1'b1;
        bus.htrans = 2'b10;
        bus.hwrite = wr;
        bus.haddr  = a;
        bus.hsize  = sz;
    endtask

    task automatic idle;
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.haddr  = '0;
        bus.hsize  = 3'd2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle();
        #1;
        @(negedge clk);
        n_run++;
        if (sram_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_cs_n: got %b want 1", sram_cs_n);
        end
        n_run++;
        if ({sram_we_n, sram_be_n} !== 5'h1f) begin
            n_fail++;
            $display("FAIL rst_we_be: got %h want 1f", {sram_we_n, sram_be_n});
        end
        n_run++;
        if ({bus.hready_resp, bus.hresp} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_resp: got %b want 10", {bus.hready_resp, bus.hresp});
        end
        n_run++;
        if (bus.hrdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_hrdata: got %h want 0", bus.hrdata);
        end
        cyc();
        rst_n = 1'b1;
        aph(1'b0, 32'h0, 3'd2);
        @(negedge clk);
        n_run++;
        if (sram_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL first_cycle_cs_n: got %b want 1", sram_cs_n);
        end
        cyc();
        idle();
        cyc();
    endtask

    task automatic test_word_write;
        aph(1'b1, 32'h40, 3'd2);
        @(negedge clk);
        n_run++;
        if (sram_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL ww_aph_idle: got cs_n %b want 1", sram_cs_n);
        end
        cyc();
        idle();
        bus.hwdata = 32'hdeadbeef;
        @(negedge clk);
        n_run++;
        if ({sram_cs_n, sram_we_n, sram_be_n} !== 6'h00) begin
            n_fail++;
            $display("FAIL ww_ctl: got %h want 00", {sram_cs_n, sram_we_n, sram_be_n});
        end
        n_run++;
        if (sram_addr !== 11'h10 || sram_wdata !== 32'hdeadbeef) begin
            n_fail++;
            $display("FAIL ww_addr_data: got %h/%h want 010/deadbeef", sram_addr, sram_wdata);
        end
        n_run++;
        if (dut.wbuf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ww_wbuf: got %b want 0", dut.wbuf_valid);
        end
        cyc();
    endtask

    task automatic test_byte_write;
        aph(1'b1, 32'h41, 3'd0);
        cyc();
        idle();
        bus.hwdata = 32'h0000ab00;
        @(negedge clk);
        n_run++;
        if (sram_we_n !== 1'b0 || sram_be_n !== 4'b1101) begin
            n_fail++;
            $display("FAIL bw_be_n: got we %b be %b want 0/1101", sram_we_n, sram_be_n);
        end
        cyc();
        aph(1'b0, 32'h40, 3'd2);
        @(negedge clk);
        n_run++;
        if ({sram_cs_n, sram_we_n} !== 2'b01 || sram_addr !== 11'h10) begin
            n_fail++;
            $display("FAIL bw_rd_issue: got %b/%h want 01/010", {sram_cs_n, sram_we_n}, sram_addr);
        end
        cyc();
        idle();
        @(negedge clk);
        n_run++;
        if (bus.hrdata !== 32'hdeadabef) begin
            n_fail++;
            $display("FAIL bw_readback: got %h want deadabef", bus.hrdata);
        end
        cyc();
        @(negedge clk);
        n_run++;
        if (bus.hrdata !== 32'h0) begin
            n_fail++;
            $display("FAIL hrdata_idle: got %h want 0", bus.hrdata);
        end
    endtask

    task automatic test_collide;
        cyc();
        aph(1'b1, 32'h80, 3'd2);
        cyc();
        aph(1'b0, 32'h80, 3'd2);
        bus.hwdata = 32'h11223344;
        @(negedge clk);
        n_run++;
        if ({sram_cs_n, sram_we_n} !== 2'b01 || bus.hready_resp !== 1'b1) begin
            n_fail++;
            $display("FAIL col_read_wins: got %b rdy %b want 01/1", {sram_cs_n, sram_we_n}, bus.hready_resp);
        end
        cyc();
        idle();
        @(negedge clk);
        n_run++;
        if (dut.wbuf_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL col_wbuf_set: got %b want 1", dut.wbuf_valid);
        end
        n_run++;
        if (bus.hrdata !== 32'h11223344) begin
            n_fail++;
            $display("FAIL col_fwd: got %h want 11223344", bus.hrdata);
        end
        n_run++;
        if ({sram_cs_n, sram_we_n, sram_be_n} !== 6'h00 || sram_addr !== 11'h20 || sram_wdata !== 32'h11223344) begin
            n_fail++;
            $display("FAIL col_drain: got %h %h %h want 00 020 11223344", {sram_cs_n, sram_we_n, sram_be_n}, sram_addr, sram_wdata);
        end
        cyc();
        aph(1'b0, 32'h80, 3'd2);
        @(negedge clk);
        n_run++;
        if (dut.wbuf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL col_wbuf_clr: got %b want 0", dut.wbuf_valid);
        end
        cyc();
        idle();
        @(negedge clk);
        n_run++;
        if (bus.hrdata !== 32'h11223344) begin
            n_fail++;
            $display("FAIL col_mem: got %h want 11223344", bus.hrdata);
        end
        cyc();
    endtask

    task automatic test_back_to_back;
        aph(1'b1, 32'h100, 3'd2);
        cyc();
        aph(1'b0, 32'h40, 3'd2);
        bus.hwdata = 32'hcafe0001;
        cyc();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_run++;
            if (dut.wbuf_valid !== 1'b1 || sram_we_n !== 1'b1 || bus.hrdata !== 32'hdeadabef) begin
                n_fail++;
                $display("FAIL b2b_hold%0d: got wbuf %b we %b rd %h want 1/1/deadabef", k, dut.wbuf_valid, sram_we_n, bus.hrdata);
            end
            cyc();
        end
        aph(1'b1, 32'h104, 3'd2);
        @(negedge clk);
        n_run++;
        if (sram_we_n !== 1'b0 || sram_addr !== 11'h40 || sram_wdata !== 32'hcafe0001 || bus.hrdata !== 32'hdeadabef) begin
            n_fail++;
            $display("FAIL b2b_drain: got we %b %h %h rd %h want 0 040 cafe0001 deadabef", sram_we_n, sram_addr, sram_wdata, bus.hrdata);
        end
        cyc();
        idle();
        bus.hwdata = 32'hcafe0002;
        @(negedge clk);
        n_run++;
        if (sram_we_n !== 1'b0 || sram_addr !== 11'h41 || sram_wdata !== 32'hcafe0002 || dut.wbuf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_direct: got we %b %h %h wbuf %b want 0 041 cafe0002 0", sram_we_n, sram_addr, sram_wdata, dut.wbuf_valid);
        end
        cyc();
        aph(1'b0, 32'h100, 3'd2);
        cyc();
        aph(1'b0, 32'h104, 3'd2);
        @(negedge clk);
        n_run++;
        if (bus.hrdata !== 32'hcafe0001) begin
            n_fail++;
            $display("FAIL b2b_rd100: got %h want cafe0001", bus.hrdata);
        end
        cyc();
        idle();
        @(negedge clk);
        n_run++;
        if (bus.hrdata !== 32'hcafe0002) begin
            n_fail++;
            $display("FAIL b2b_rd104: got %h want cafe0002", bus.hrdata);
        end
        cyc();
    endtask

    task automatic test_half_merge;
        aph(1'b1, 32'h200, 3'd2);
        cyc();
        idle();
        bus.hwdata = 32'haaaaaaaa;
        cyc();
        aph(1'b1, 32'h202, 3'd1);
        cyc();
        aph(1'b0, 32'h200, 3'd2);
        bus.hwdata = 32'h55550000;
        @(negedge clk);
        n_run++;
        if (sram_we_n !== 1'b1 || sram_addr !== 11'h80) begin
            n_fail++;
            $display("FAIL hm_rd_issue: got we %b %h want 1 080", sram_we_n, sram_addr);
        end
        cyc();
        idle();
        @(negedge clk);
        n_run++;
        if (bus.hrdata !== 32'h5555aaaa) begin
            n_fail++;
            $display("FAIL hm_merge: got %h want 5555aaaa", bus.hrdata);
        end
        n_run++;
        if (sram_we_n !== 1'b0 || sram_be_n !== 4'b0011) begin
            n_fail++;
            $display("FAIL hm_drain_be: got we %b be %b want 0/0011", sram_we_n, sram_be_n);
        end
        cyc();
        aph(1'b0, 32'h200, 3'd2);
        cyc();
        idle();
        @(negedge clk);
        n_run++;
        if (bus.hrdata !== 32'h5555aaaa) begin
            n_fail++;
            $display("FAIL hm_mem: got %h want 5555aaaa", bus.hrdata);
        end
        cyc();
    endtask

    task automatic test_reset_mid;
        aph(1'b1, 32'h300, 3'd2);
        cyc();
        idle();
        bus.hwdata = 32'h12345678;
        cyc();
        aph(1'b1, 32'h300, 3'd2);
        cyc();
        aph(1'b0, 32'h10, 3'd2);
        bus.hwdata = 32'h87654321;
        cyc();
        idle();
        n_run++;
        if (dut.wbuf_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_wbuf_set: got %b want 1", dut.wbuf_valid);
        end
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({sram_cs_n, sram_we_n, sram_be_n} !== 6'h3f || bus.hrdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_outputs: got %h rd %h want 3f/0", {sram_cs_n, sram_we_n, sram_be_n}, bus.hrdata);
        end
        n_run++;
        if (dut.wbuf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_wbuf_clr: got %b want 0", dut.wbuf_valid);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        aph(1'b0, 32'h300, 3'd2);
        cyc();
        idle();
        @(negedge clk);
        n_run++;
        if (bus.hrdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rm_old_data: got %h want 12345678", bus.hrdata);
        end
        cyc();
    endtask

    initial begin
        n_run      = 0;
        n_fail     = 0;
        bus.hready = 1'b1;
        bus.hwdata = '0;
        idle();
        test_reset();
        test_word_write();
        test_byte_write();
        test_collide();
        test_back_to_back();
        test_half_merge();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
